// File: rtl/code_entry_rx_pkg.sv
// Shared types and ASCII constants for the passcode entry receive sequencer.
package entry_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAITBYTE,
      ACK,
      CHECK,
      EVAL,
      GRANT,
      DENY
   } entry_state_t;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

endpackage

// File: rtl/code_entry_rx_if.sv
// Ready/read handshake between the UART receiver (master) and the entry sequencer (slave).
interface code_entry_rx_if;

   logic       rxready;
   logic [7:0] rxdata;
   logic       rdrxdata;

   modport master (output rxready, output rxdata, input rdrxdata);
   modport slave  (input rxready, input rxdata, output rdrxdata);

endinterface

// File: rtl/code_entry_rx_gap_timer.sv
// Inter-byte gap timer; expired is asserted in the last allowed idle cycle.
module gap_timer #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + W'(1);
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/code_entry_rx.sv
// Collects a CR-terminated decimal code from the UART receiver and reports grant or deny.
module code_entry_rx
   import entry_pkg::*;
#(
   parameter int CODE_LEN       = 4,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   code_entry_rx_if.slave        rx,
   input  logic [4*CODE_LEN-1:0] code,
   output logic                  busy,
   output logic [3:0]            digit_count,
   output logic                  granted,
   output logic                  denied,
   output logic                  timeout,
   output logic                  done
);

   localparam int BUF_W = 4 * CODE_LEN;
   localparam logic [3:0] LEN = 4'(CODE_LEN);

   entry_state_t     state, next_state;
   logic [7:0]       byte_reg;
   logic [BUF_W-1:0] buffer;
   logic             error_flag;
   logic             from_wait;
   logic             expired;

   gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != WAITBYTE),
      .enable  (state == WAITBYTE),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start) next_state = WAITBYTE;
         WAITBYTE: begin
            if (rx.rxready)
               next_state = ACK;
            else if (expired)
               next_state = DENY;
         end
         ACK:      next_state = CHECK;
         CHECK:    next_state = (byte_reg == ASCII_CR) ? EVAL : WAITBYTE;
         EVAL: begin
            if (!error_flag && (digit_count == LEN) && (buffer == code))
               next_state = GRANT;
            else
               next_state = DENY;
         end
         GRANT:    next_state = IDLE;
         DENY:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // from_wait remembers whether DENY was reached through the gap timer rather than EVAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_reg    <= '0;
         buffer      <= '0;
         digit_count <= '0;
         error_flag  <= 1'b0;
         from_wait   <= 1'b0;
      end else begin
         from_wait <= (state == WAITBYTE);
         case (state)
            IDLE: begin
               buffer      <= '0;
               digit_count <= '0;
               error_flag  <= 1'b0;
            end
            WAITBYTE: begin
               if (rx.rxready)
                  byte_reg <= rx.rxdata;
            end
            CHECK: begin
               if (is_digit(byte_reg)) begin
                  if (digit_count < LEN)
                     buffer <= (buffer << 4) | BUF_W'(byte_reg[3:0]);
                  else
                     error_flag <= 1'b1;
                  if (digit_count != 4'hF)
                     digit_count <= digit_count + 4'd1;
               end else if (byte_reg != ASCII_CR) begin
                  error_flag <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign rx.rdrxdata = (state == ACK);
   assign granted     = (state == GRANT);
   assign denied      = (state == DENY);
   assign timeout     = (state == DENY) && from_wait;
   assign done        = granted | denied;

endmodule

// File: doc/code_entry_rx.md
# code_entry_rx

Receive-side sequencer for passcode entry over the UART link. It takes ASCII bytes from the UART receiver using the receiver's ready/read handshake and collects a fixed-length decimal code terminated by carriage return. It then compares the code with the stored code and reports grant or deny. It is the counterpart of the post-entry transmit sequencer and sits between the UART receiver and the top-level security controller.

## Interface
- `CODE_LEN`, default 4: number of decimal digits in a valid code (1–8).
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle clocks allowed between bytes once entry has started.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a new entry; sampled only in IDLE.
- `rxready`  in  1  receiver holds a byte; stays high until `rdrxdata`.
- `rxdata`  in  8  received byte; valid while `rxready`=1.
- `code`  in  4*CODE_LEN  stored code, BCD, most significant digit in the top nibble.
- `rdrxdata`  out  1  one-cycle read strobe that clears the receiver's ready flag.
- `busy`  out  1  high in every state except IDLE.
- `digit_count`  out  4  digits accepted so far; saturates at 15.
- `granted`  out  1  one-cycle pulse: code matched.
- `denied`  out  1  one-cycle pulse: mismatch, bad format or timeout.
- `timeout`  out  1  one-cycle pulse, concurrent with `denied`, when the gap timer expired.
- `done`  out  1  one-cycle pulse, concurrent with `granted` or `denied`.

## Operation
- States: IDLE, WAITBYTE, ACK, CHECK, EVAL, GRANT, DENY.
- **IDLE**
  - Clears the digit buffer, `digit_count` and the error flag.
  - `start`=1 → WAITBYTE.
- **WAITBYTE**
  - The gap timer is cleared on entry and increments every cycle in this state.
  - `rxready`=1 → capture `rxdata` into a byte register, go to ACK.
  - Otherwise, timer == TIMEOUT_CYCLES-1 → DENY with `timeout`.
  - `rxready` takes priority when both occur in the same cycle.
- **ACK**
  - `rdrxdata`=1 for this single cycle, then CHECK.
  - `rxready`/`rxdata` are not re-sampled here.
- **CHECK**, classifying the captured byte:
  - '0'..'9' (0x30–0x39), with digit_count < CODE_LEN: shift the low nibble into the buffer, increment the count, go to WAITBYTE.
  - A digit when digit_count ≥ CODE_LEN: set the error flag, increment the count (saturating), go to WAITBYTE.
  - CR (0x0D) → EVAL.
  - Any other byte: set the error flag, go to WAITBYTE. Entry continues until CR or timeout.
- **EVAL**: → GRANT when the error flag is clear, digit_count == CODE_LEN and buffer == `code`; otherwise → DENY.
- **GRANT** and **DENY** last one cycle each, then → IDLE.
  - GRANT drives `granted`=1 and `done`=1.
  - DENY drives `denied`=1 and `done`=1, plus `timeout`=1 when it was reached from WAITBYTE.
- Outputs are Moore-decoded from the registered state, except `digit_count`, which is a register.
- `start` while `busy`: ignored.
- CR as the first byte: digit_count 0 → DENY.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A byte still pending in the receiver is not read until the next entry.

## Timing
- Reset values: `rdrxdata`, `busy`, `granted`, `denied`, `timeout` and `done` are 0; `digit_count` is 0; state is IDLE; the buffer and timer are 0.
- `start` sampled at edge s → `busy`=1 from s.
- `rxready` sampled at edge k → `rdrxdata` high during cycle k..k+1.
- Per-digit turnaround is 3 cycles: WAITBYTE → ACK → CHECK → WAITBYTE. A new `rxready` is sampled no earlier than edge k+3.
- CR sampled at edge k → `granted`/`denied`/`done` high during cycle k+3..k+4 → IDLE at k+4.
- Timeout: `denied`, `timeout` and `done` rise TIMEOUT_CYCLES cycles after the WAITBYTE entry edge.
- At most one `rdrxdata` pulse per received byte. Every byte read is consumed exactly once.

## Structure
- Package `entry_pkg` holds:
  - the state enum `entry_state_t`;
  - the constants ASCII_0=8'h30, ASCII_9=8'h39, ASCII_CR=8'h0D.
- Sub-module `gap_timer`, parameterised by TIMEOUT_CYCLES:
  - inputs `clk`, `rst_n`, `clear`, `enable`;
  - output `expired`;
  - counter width $clog2(TIMEOUT_CYCLES+1).
- The buffer is a CODE_LEN×4-bit shift register; the comparison is a single equality in EVAL.

## Test plan
- Reset mid-entry: after 2 digits, pulse `rst_n` low asynchronously → all outputs 0 immediately, `busy`=0; the next entry starts with `digit_count`=0.
- Match: CODE_LEN=4, `code`=16'h1234, bytes "1","2","3","4",CR → four `rdrxdata` pulses, `digit_count` 1→4, `granted`=`done`=1 exactly 3 cycles after CR is sampled, then `busy`=0.
- Mismatch: `code`=16'h1234, bytes "1","2","3","5",CR → `denied`=`done`=1, `granted`=0, `timeout`=0.
- Format errors, each followed by CR → `denied` with no `timeout`:
  - "12A4": illegal character;
  - "12345": too many digits;
  - "123": too few digits;
  - lone CR: no digits.
- Timeout: TIMEOUT_CYCLES=20, send "1" and then nothing → `denied`=`timeout`=`done`=1, 20 cycles after re-entering WAITBYTE.
- Back-to-back: `rxready` held high continuously with the next byte presented the cycle after each `rdrxdata` → exactly one `rdrxdata` per byte, no byte lost or duplicated. `start` asserted while `busy` has no effect.
